id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/rv_pkg.sv | 60 ++++++
 rtl/fwd_mux.sv | 24 ++
 rtl/id_ex_stage.sv | 142 ++++++++++++++
 tb/tb_id_ex_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32 definitions: opcodes, one-hot ALU bit positions and the EX control bundle.
package rv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam int ALU_W    = 10;
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLL  = 2;
  localparam int ALU_SLT  = 3;
  localparam int ALU_SLTU = 4;
  localparam int ALU_XOR  = 5;
  localparam int ALU_SRL  = 6;
  localparam int ALU_SRA  = 7;
  localparam int ALU_OR   = 8;
  localparam int ALU_AND  = 9;

  typedef enum logic [1:0] {A_ZERO = 2'd0, A_RS1 = 2'd1, A_PC = 2'd2} a_sel_e;
  typedef enum logic [1:0] {B_IMM = 2'd0, B_RS2 = 2'd1, B_FOUR = 2'd2} b_sel_e;

  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic             memread;
    logic             memwrite;
    logic [ALU_W-1:0] alu_ctrl;
    a_sel_e           a_sel;
    b_sel_e           b_sel;
  } ex_ctl_t;

  function automatic logic [ALU_W-1:0] alu_onehot(input int idx);
    logic [ALU_W-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  // alt selects SUB over ADD and SRA over SRL.
  function automatic logic [ALU_W-1:0] alu_decode(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'd0:    return alu_onehot(alt ? ALU_SUB : ALU_ADD);
      3'd1:    return alu_onehot(ALU_SLL);
      3'd2:    return alu_onehot(ALU_SLT);
      3'd3:    return alu_onehot(ALU_SLTU);
      3'd4:    return alu_onehot(ALU_XOR);
      3'd5:    return alu_onehot(alt ? ALU_SRA : ALU_SRL);
      3'd6:    return alu_onehot(ALU_OR);
      default: return alu_onehot(ALU_AND);
    endcase
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass: EX/MEM beats MEM/WB beats the register-file value; x0 always reads 0.
module fwd_mux #(
  parameter int XLEN = 32
) (
  input  logic [4:0]      rs,
  input  logic [XLEN-1:0] reg_val,
  input  logic [4:0]      exmem_rd,
  input  logic            exmem_regwrite,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [4:0]      memwb_rd,
  input  logic            memwb_regwrite,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] operand
);

  // rs != 0 also guarantees the matching rd is non-zero.
  always_comb begin
    if (rs == 5'd0)                                operand = '0;
    else if (exmem_regwrite && (exmem_rd == rs))   operand = exmem_result;
    else if (memwb_regwrite && (memwb_rd == rs))   operand = memwb_result;
    else                                           operand = reg_val;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with registered ALU decode, operand forwarding and load-use detection.
module id_ex_stage
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [6:0]       id_opcode,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7_5,
  input  logic [4:0]       exmem_rd,
  input  logic             exmem_regwrite,
  input  logic [XLEN-1:0]  exmem_result,
  input  logic [4:0]       memwb_rd,
  input  logic             memwb_regwrite,
  input  logic [XLEN-1:0]  memwb_result,
  output logic             ex_valid,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [ALU_W-1:0] alu_ctrl,
  output logic [XLEN-1:0]  ex_store_data,
  output logic             load_use_stall
);

  ex_ctl_t         dec, ctl_q;
  logic            alt;
  logic [4:0]      rs1_q, rs2_q;
  logic [XLEN-1:0] rs1_data_q, rs2_data_q, imm_q;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;

  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a latch behind.
    dec       = '0;
    dec.a_sel = A_RS1;
    dec.b_sel = B_IMM;
    alt       = id_funct7_5 & ((id_opcode == OPC_OP) | (id_funct3 == 3'd5));
    case (id_opcode)
      OPC_OP:     begin dec.valid = 1'b1; dec.regwrite = 1'b1;
                        dec.alu_ctrl = alu_decode(id_funct3, alt); dec.b_sel = B_RS2; end
      OPC_OP_IMM: begin dec.valid = 1'b1; dec.regwrite = 1'b1;
                        dec.alu_ctrl = alu_decode(id_funct3, alt); end
      OPC_LOAD:   begin dec.valid = 1'b1; dec.regwrite = 1'b1; dec.memread = 1'b1;
                        dec.alu_ctrl = alu_onehot(ALU_ADD); end
      OPC_STORE:  begin dec.valid = 1'b1; dec.memwrite = 1'b1;
                        dec.alu_ctrl = alu_onehot(ALU_ADD); end
      OPC_BRANCH: begin dec.valid = 1'b1; dec.alu_ctrl = alu_onehot(ALU_SUB); dec.b_sel = B_RS2; end
      OPC_LUI:    begin dec.valid = 1'b1; dec.regwrite = 1'b1;
                        dec.alu_ctrl = alu_onehot(ALU_ADD); dec.a_sel = A_ZERO; end
      OPC_AUIPC:  begin dec.valid = 1'b1; dec.regwrite = 1'b1;
                        dec.alu_ctrl = alu_onehot(ALU_ADD); dec.a_sel = A_PC; end
      OPC_JAL, OPC_JALR: begin dec.valid = 1'b1; dec.regwrite = 1'b1;
                        dec.alu_ctrl = alu_onehot(ALU_ADD); dec.a_sel = A_PC; dec.b_sel = B_FOUR; end
      default: ;
    endcase
    // Empty slots and unknown opcodes both enter EX as a bubble.
    if (!(id_valid && dec.valid)) dec = '0;
  end

  assign load_use_stall = ctl_q.valid & ctl_q.memread & (ex_rd != 5'd0) & id_valid &
                          ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
      ctl_q      <= '0;
      ex_rd      <= '0;
      ex_funct3  <= '0;
      ex_pc      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else begin
      if (flush || (!stall && load_use_stall)) ctl_q <= '0;
      else if (!stall)                         ctl_q <= dec;
      // Payload is don't-care under a bubble, so it only honours stall.
      if (!stall) begin
        ex_rd      <= id_rd;
        ex_funct3  <= id_funct3;
        ex_pc      <= id_pc;
        rs1_q      <= id_rs1;
        rs2_q      <= id_rs2;
        rs1_data_q <= id_rs1_data;
        rs2_data_q <= id_rs2_data;
        imm_q      <= id_imm;
      end
    end
  end

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
    .rs(rs1_q), .reg_val(rs1_data_q),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .memwb_result(memwb_result),
    .operand(rs1_fwd)
  );

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
    .rs(rs2_q), .reg_val(rs2_data_q),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .memwb_result(memwb_result),
    .operand(rs2_fwd)
  );

  always_comb begin
    case (ctl_q.a_sel)
      A_RS1:   alu_a = rs1_fwd;
      A_PC:    alu_a = ex_pc;
      default: alu_a = '0;
    endcase
    case (ctl_q.b_sel)
      B_RS2:   alu_b = rs2_fwd;
      B_FOUR:  alu_b = XLEN'(4);
      default: alu_b = imm_q;
    endcase
  end

  assign ex_valid      = ctl_q.valid;
  assign ex_regwrite   = ctl_q.regwrite;
  assign ex_memread    = ctl_q.memread;
  assign ex_memwrite   = ctl_q.memwrite;
  assign alu_ctrl      = ctl_q.alu_ctrl;
  assign ex_store_data = rs2_fwd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: instruction-level model compared every cycle plus literal spot checks.
module tb_id_ex_stage;

  localparam logic [6:0] LOAD = 7'h03, OPIMM = 7'h13, AUIPC = 7'h17, STORE = 7'h23,
                         OP = 7'h33, LUI = 7'h37, BRANCH = 7'h63, JALR = 7'h67, JAL = 7'h6f;

  logic        clk = 1'b0, rst, stall, flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic        id_funct7_5;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_regwrite, memwb_regwrite;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, load_use_stall;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, alu_a, alu_b, ex_store_data;
  logic [9:0]  alu_ctrl;

  int n_cmp = 0;
  int n_bad = 0;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7_5(id_funct7_5),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_pc(ex_pc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .ex_store_data(ex_store_data),
    .load_use_stall(load_use_stall)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the instruction sitting in EX, kept as its raw decoded fields.
  typedef struct packed {
    logic        valid;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] pc, rs1v, rs2v, imm;
  } ex_model_t;

  ex_model_t m;

  function automatic logic known(input logic [6:0] op);
    return op inside {LOAD, OPIMM, AUIPC, STORE, OP, LUI, BRANCH, JALR, JAL};
  endfunction

  function automatic logic hazard(input ex_model_t e);
    return e.valid && e.op == LOAD && e.rd != 0 && id_valid && (e.rd == id_rs1 || e.rd == id_rs2);
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] v);
    if (rs == 0) return 0;
    if (exmem_regwrite && exmem_rd == rs) return exmem_result;
    if (memwb_regwrite && memwb_rd == rs) return memwb_result;
    return v;
  endfunction

  function automatic logic [9:0] exp_ctrl(input ex_model_t e);
    int base[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int idx;
    logic [9:0] one = 10'd1;
    case (e.op)
      OP:      idx = base[e.f3] + ((e.f7 && (e.f3 == 0 || e.f3 == 5)) ? 1 : 0);
      OPIMM:   idx = base[e.f3] + ((e.f7 && e.f3 == 5) ? 1 : 0);
      BRANCH:  idx = 1;
      default: idx = 0;
    endcase
    return one << idx;
  endfunction

  function automatic ex_model_t model_next(input ex_model_t e);
    ex_model_t n = e;
    if (flush) n.valid = 0;
    else if (stall) n = e;
    else if (hazard(e) || !id_valid || !known(id_opcode)) n.valid = 0;
    else n = '{1'b1, id_opcode, id_funct3, id_funct7_5, id_rd, id_rs1, id_rs2,
               id_pc, id_rs1_data, id_rs2_data, id_imm};
    return n;
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) m <= '0;
    else     m <= model_next(m);

  always @(negedge clk) begin
    if (!rst) begin
      check("m_load_use", 32'(load_use_stall), 32'(hazard(m)));
      check("m_valid", 32'(ex_valid), 32'(m.valid));
      if (!m.valid) begin
        check("m_bub_ctrl", 32'(alu_ctrl), 0);
        check("m_bub_rw", 32'({ex_regwrite, ex_memread, ex_memwrite}), 0);
      end else begin
        check("m_ctrl", 32'(alu_ctrl), 32'(exp_ctrl(m)));
        check("m_regwrite", 32'(ex_regwrite), 32'(!(m.op == STORE || m.op == BRANCH)));
        check("m_memread", 32'(ex_memread), 32'(m.op == LOAD));
        check("m_memwrite", 32'(ex_memwrite), 32'(m.op == STORE));
        check("m_rd", 32'(ex_rd), 32'(m.rd));
        check("m_funct3", 32'(ex_funct3), 32'(m.f3));
        check("m_pc", ex_pc, m.pc);
        check("m_alu_a", alu_a, (m.op == LUI) ? 32'd0 :
                                (m.op inside {AUIPC, JAL, JALR}) ? m.pc : fwd(m.rs1, m.rs1v));
        check("m_alu_b", alu_b, (m.op inside {OP, BRANCH}) ? fwd(m.rs2, m.rs2v) :
                                (m.op inside {JAL, JALR}) ? 32'd4 : m.imm);
        check("m_store", ex_store_data, fwd(m.rs2, m.rs2v));
      end
    end
  end

  task automatic wait_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] imm, input logic [31:0] pc);
    id_valid = 1'b1; id_opcode = op; id_funct3 = f3; id_funct7_5 = f7;
    id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_rs1_data = v1; id_rs2_data = v2; id_imm = imm; id_pc = pc;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(ex_valid), 0);
    check({tag, "_ctl"}, 32'({ex_regwrite, ex_memread, ex_memwrite}), 0);
    check({tag, "_rd"}, 32'(ex_rd), 0);
    check({tag, "_funct3"}, 32'(ex_funct3), 0);
    check({tag, "_pc"}, ex_pc, 0);
    check({tag, "_alu_a"}, alu_a, 0);
    check({tag, "_alu_b"}, alu_b, 0);
    check({tag, "_alu_ctrl"}, 32'(alu_ctrl), 0);
    check({tag, "_store"}, ex_store_data, 0);
    check({tag, "_lus"}, 32'(load_use_stall), 0);
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0; id_valid = 0;
    id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_opcode = 0; id_funct3 = 0; id_funct7_5 = 0;
    exmem_rd = 0; exmem_regwrite = 0; exmem_result = 0;
    memwb_rd = 0; memwb_regwrite = 0; memwb_result = 0;
    #1 check_all_zero("reset");
    wait_edge();
    rst = 0;

    // ADD x3,x1,x2
    drive(OP, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 32'h100);
    wait_edge();
    check("add_ctrl", 32'(alu_ctrl), 32'h001);
    check("add_a", alu_a, 32'd5);
    check("add_b", alu_b, 32'd7);
    check("add_rd", 32'(ex_rd), 32'd3);

    // Forwarding priority on the ADD now in EX
    exmem_rd = 5'd1; exmem_regwrite = 1; exmem_result = 32'h10;
    memwb_rd = 5'd1; memwb_regwrite = 1; memwb_result = 32'h20;
    #1 check("fwd_exmem", alu_a, 32'h10);
    exmem_rd = 5'd0;
    #1 check("fwd_memwb", alu_a, 32'h20);
    exmem_rd = 5'd2;
    #1 check("fwd_b", alu_b, 32'h10);
    check("fwd_store", ex_store_data, 32'h10);
    exmem_rd = 5'd0; memwb_regwrite = 0;
    #1 check("fwd_none", alu_a, 32'd5);

    // SUB x4,x0,x2: x0 ignores its data and forwards, rs2 from MEM/WB
    memwb_rd = 5'd2; memwb_regwrite = 1; memwb_result = 32'h77;
    drive(OP, 3'd0, 1'b1, 5'd4, 5'd0, 5'd2, 32'h99, 32'd7, 32'd0, 32'h104);
    wait_edge();
    check("sub_ctrl", 32'(alu_ctrl), 32'h002);
    check("sub_x0", alu_a, 32'd0);
    check("sub_b_memwb", alu_b, 32'h77);
    exmem_regwrite = 0; memwb_regwrite = 0;

    drive(OPIMM, 3'd5, 1'b1, 5'd8, 5'd1, 5'd0, 32'h8000_0000, 32'd0, 32'd4, 32'h108);
    wait_edge();
    check("srai_ctrl", 32'(alu_ctrl), 32'h080);
    check("srai_b", alu_b, 32'd4);

    drive(LUI, 3'd0, 1'b0, 5'd7, 5'd9, 5'd0, 32'h55, 32'd0, 32'h1234_5000, 32'h10c);
    wait_edge();
    check("lui_a", alu_a, 32'd0);
    check("lui_b", alu_b, 32'h1234_5000);
    check("lui_ctrl", 32'(alu_ctrl), 32'h001);

    drive(AUIPC, 3'd0, 1'b0, 5'd8, 5'd0, 5'd0, 32'd0, 32'd0, 32'h1000, 32'h200);
    wait_edge();
    check("auipc_a", alu_a, 32'h200);
    drive(JAL, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 32'h40, 32'h300);
    wait_edge();
    check("jal_b", alu_b, 32'd4);
    drive(JALR, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'h123, 32'd0, 32'h8, 32'h304);
    wait_edge();
    check("jalr_a", alu_a, 32'h304);
    drive(BRANCH, 3'd1, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3, 32'd3, 32'h10, 32'h308);
    wait_edge();
    check("br_regwrite", 32'(ex_regwrite), 0);
    drive(STORE, 3'd2, 1'b0, 5'd0, 5'd2, 5'd3, 32'h1000, 32'hdead, 32'h8, 32'h30c);
    wait_edge();
    check("sw_store", ex_store_data, 32'hdead);
    check("sw_memwrite", 32'(ex_memwrite), 1);

    for (int f = 0; f < 8; f++) begin
      drive(OP, 3'(f), 1'b0, 5'd10, 5'd11, 5'd12, 32'd100 + 32'(f), 32'd3, 32'd0, 32'h310);
      wait_edge();
    end
    check("and_ctrl", 32'(alu_ctrl), 32'h200);

    // LW x5 then ADD x6,x5,x1
    drive(LOAD, 3'd2, 1'b0, 5'd5, 5'd2, 5'd0, 32'h1000, 32'd0, 32'd8, 32'h400);
    wait_edge();
    check("lw_memread", 32'(ex_memread), 1);
    drive(OP, 3'd0, 1'b0, 5'd6, 5'd5, 5'd1, 32'h11, 32'd5, 32'd0, 32'h404);
    #1 check("lu_stall", 32'(load_use_stall), 1);
    wait_edge();
    check("lu_bubble_valid", 32'(ex_valid), 0);
    check("lu_bubble_ctrl", 32'(alu_ctrl), 0);
    check("lu_released", 32'(load_use_stall), 0);
    wait_edge();
    check("lu_issue_rd", 32'(ex_rd), 32'd6);
    check("lu_issue_ctrl", 32'(alu_ctrl), 32'h001);

    // Stall holds the ADD for three edges, then flush wins over stall
    stall = 1;
    drive(OP, 3'd4, 1'b0, 5'd9, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 32'h408);
    for (int i = 0; i < 3; i++) begin
      wait_edge();
      check("stall_rd", 32'(ex_rd), 32'd6);
      check("stall_pc", ex_pc, 32'h404);
      check("stall_ctrl", 32'(alu_ctrl), 32'h001);
    end
    flush = 1;
    wait_edge();
    check("flush_valid", 32'(ex_valid), 0);
    flush = 0; stall = 0;
    wait_edge();
    check("xor_ctrl", 32'(alu_ctrl), 32'h020);

    drive(7'h7f, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 32'h500);
    wait_edge();
    check("unknown_valid", 32'(ex_valid), 0);
    drive(OP, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 32'h504);
    id_valid = 0;
    wait_edge();
    check("idle_valid", 32'(ex_valid), 0);

    // Async reset in the middle of a load-use hazard
    drive(LOAD, 3'd2, 1'b0, 5'd5, 5'd2, 5'd0, 32'h1000, 32'd0, 32'd8, 32'h600);
    wait_edge();
    drive(OP, 3'd0, 1'b0, 5'd6, 5'd5, 5'd1, 32'h11, 32'd5, 32'd0, 32'h604);
    #1 check("pre_rst_lus", 32'(load_use_stall), 1);
    rst = 1;
    #1 check_all_zero("async_rst");
    rst = 0;
    wait_edge();
    check("post_rst_valid", 32'(ex_valid), 1);
    check("post_rst_rd", 32'(ex_rd), 32'd6);

    id_valid = 0;
    wait_edge();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
